// File: rtl/approx_err_if.sv
// Handshake and result bundle between the approximate multiplier stream and its error monitor.
interface approx_err_if #(
  parameter int CNT_W = 16,
  parameter int SUM_W = 32
);
  logic             start;
  logic [CNT_W-1:0] n_samples;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       a;
  logic [7:0]       b;
  logic [15:0]      r_approx;
  logic             done;
  logic [SUM_W-1:0] sum_err;
  logic [15:0]      max_err;
  logic [CNT_W-1:0] nz_cnt;
  logic             sum_sat;

  modport master (
    output start, n_samples, in_valid, a, b, r_approx,
    input  busy, in_ready, done, sum_err, max_err, nz_cnt, sum_sat
  );

  modport slave (
    input  start, n_samples, in_valid, a, b, r_approx,
    output busy, in_ready, done, sum_err, max_err, nz_cnt, sum_sat
  );
endinterface

// File: rtl/approx_err_monitor.sv
// Accumulates |a*b - r_approx| statistics over a run of N samples from the approximate multiplier.
module approx_err_monitor #(
  parameter int CNT_W = 16,
  parameter int SUM_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  approx_err_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int ACC_W = ((SUM_W > 16) ? SUM_W : 16) + 1;

  function automatic logic [15:0] abs_err(input logic [15:0] exact, input logic [15:0] approx);
    logic signed [16:0] diff;
    diff = $signed({1'b0, exact}) - $signed({1'b0, approx});
    return (diff < 17'sd0) ? 16'(-diff) : 16'(diff);
  endfunction

  // Returns {overflow, clamped sum}.
  function automatic logic [SUM_W:0] sat_add(input logic [SUM_W-1:0] acc, input logic [15:0] ed);
    logic [ACC_W-1:0] total;
    total = ACC_W'(acc) + ACC_W'(ed);
    if (total > ACC_W'({SUM_W{1'b1}})) return {1'b1, {SUM_W{1'b1}}};
    return {1'b0, total[SUM_W-1:0]};
  endfunction

  state_t           state_q;
  logic             busy_q, in_ready_q, done_q;
  logic [CNT_W-1:0] n_q, cnt_q;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [15:0]      max_q, max_d;
  logic [CNT_W-1:0] nz_q, nz_d;
  logic             sat_q, sat_d;
  logic [SUM_W:0]   sum_ext;

  logic             vld_p1, vld_p2;
  logic [15:0]      exact_p1, approx_p1, ed_p2;

  logic accept;
  logic start_ok;

  assign accept   = bus.in_valid & in_ready_q;
  assign start_ok = (state_q == IDLE) && bus.start && (bus.n_samples != '0);

  // Stage 1: exact product alongside the approximate one
  always_ff @(posedge clk) begin
    if (accept) begin
      exact_p1  <= 16'(bus.a) * 16'(bus.b);
      approx_p1 <= bus.r_approx;
    end
    // Stage 2: absolute error
    if (vld_p1) begin
      ed_p2 <= abs_err(exact_p1, approx_p1);
    end
  end

  // Stage 3: accumulator next-state
  always_comb begin
    sum_ext = sat_add(sum_q, ed_p2);
    sum_d   = sum_q;
    max_d   = max_q;
    nz_d    = nz_q;
    sat_d   = sat_q;
    if (start_ok) begin
      sum_d = '0;
      max_d = '0;
      nz_d  = '0;
      sat_d = 1'b0;
    end else if (vld_p2) begin
      sum_d = sum_ext[SUM_W-1:0];
      sat_d = sat_q | sum_ext[SUM_W];
      if (ed_p2 > max_q) max_d = ed_p2;
      if (ed_p2 != '0)   nz_d  = nz_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
      n_q        <= '0;
      cnt_q      <= '0;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      sum_q      <= '0;
      max_q      <= '0;
      nz_q       <= '0;
      sat_q      <= 1'b0;
    end else begin
      vld_p1 <= accept;
      vld_p2 <= vld_p1;
      done_q <= 1'b0;
      sum_q  <= sum_d;
      max_q  <= max_d;
      nz_q   <= nz_d;
      sat_q  <= sat_d;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            n_q        <= bus.n_samples;
            cnt_q      <= '0;
            state_q    <= RUN;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q + CNT_W'(1) == n_q) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Wait until the last accepted sample has reached the accumulators.
          if (!vld_p1 && !vld_p2) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.in_ready = in_ready_q;
  assign bus.done     = done_q;
  assign bus.sum_err  = sum_q;
  assign bus.max_err  = max_q;
  assign bus.nz_cnt   = nz_q;
  assign bus.sum_sat  = sat_q;
endmodule

// File: tb/tb_approx_err_monitor.sv
// Randomized self-checking bench for approx_err_monitor against a queue-based statistics model.
module tb_approx_err_monitor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  approx_err_if #(.CNT_W(16), .SUM_W(32)) bus0 ();
  approx_err_if #(.CNT_W(16), .SUM_W(8))  bus1 ();

  approx_err_monitor #(.CNT_W(16), .SUM_W(32)) u_dut (.clk(clk), .rst(rst), .bus(bus0));
  approx_err_monitor #(.CNT_W(16), .SUM_W(8))  u_sat (.clk(clk), .rst(rst), .bus(bus1));

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  qa[$];
  logic [7:0]  qb[$];
  logic [15:0] qr[$];
  bit          vpat[$];

  longint exp_sum;
  int     exp_max;
  int     exp_nz;
  bit     exp_sat;

  function automatic int ref_err(int a, int b, int r);
    int d;
    d = a * b - r;
    return (d < 0) ? -d : d;
  endfunction

  task automatic model(input int n, input longint sat_max);
    exp_sum = 0; exp_max = 0; exp_nz = 0; exp_sat = 0;
    for (int i = 0; i < n; i++) begin
      int e;
      e = ref_err(int'(qa[i]), int'(qb[i]), int'(qr[i]));
      exp_sum += e;
      if (e > exp_max) exp_max = e;
      if (e != 0) exp_nz++;
    end
    if (exp_sum > sat_max) begin
      exp_sum = sat_max;
      exp_sat = 1;
    end
  endtask

  task automatic clear_q();
    qa.delete(); qb.delete(); qr.delete(); vpat.delete();
  endtask

  task automatic push(input int a, input int b, input int r);
    qa.push_back(8'(a)); qb.push_back(8'(b)); qr.push_back(16'(r));
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) begin
      int a, b, ex, r, sel;
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      ex = a * b;
      sel = $urandom_range(0, 3);
      if (sel == 0)      r = ex;
      else if (sel == 3) r = $urandom_range(0, 65535);
      else begin
        r = ex + $urandom_range(0, 400) - 200;
        if (r < 0) r = 0;
        if (r > 65535) r = 65535;
      end
      push(a, b, r);
    end
  endtask

  // start_mode: 0 = no start during run, 1 = random start pulses, 2 = start held high
  task automatic run0(input int n, input int start_mode, input bit rand_valid);
    int acc, last, cyc;
    bit seen_done, v;
    acc = 0; last = -100; cyc = 0; seen_done = 0;
    model(n, 64'hFFFF_FFFF);
    @(negedge clk);
    bus0.start = 1'b1; bus0.n_samples = 16'(n); bus0.in_valid = 1'b0;
    @(negedge clk);
    while (!seen_done && cyc < 3000) begin
      if (bus0.done === 1'b1) begin
        seen_done = 1;
      end else begin
        n_checks++;
        if (bus0.in_ready !== (acc < n) || bus0.busy !== 1'b1) begin
          $display("FAIL run_handshake cyc=%0d in_ready=%b busy=%b required in_ready=%b busy=1",
                   cyc, bus0.in_ready, bus0.busy, (acc < n));
        end else n_pass++;
        case (start_mode)
          0:       bus0.start = 1'b0;
          1:       bus0.start = ($urandom_range(0, 5) == 0);
          default: bus0.start = 1'b1;
        endcase
        bus0.n_samples = 16'($urandom_range(1, 100));
        if (vpat.size() > cyc) v = vpat[cyc];
        else if (rand_valid)   v = ($urandom_range(0, 2) != 0);
        else                   v = 1'b1;
        bus0.in_valid = v;
        if (acc < n) begin
          bus0.a = qa[acc]; bus0.b = qb[acc]; bus0.r_approx = qr[acc];
        end else begin
          bus0.a = 8'($urandom); bus0.b = 8'($urandom); bus0.r_approx = 16'($urandom);
        end
        if (v && acc < n) begin
          acc++;
          if (acc == n) last = cyc;
        end
        @(negedge clk);
        cyc++;
      end
    end
    bus0.start = 1'b0; bus0.in_valid = 1'b0;
    n_checks++;
    if (!seen_done || cyc != last + 4) begin
      $display("FAIL done_timing done_seen=%b at cyc=%0d required cyc=%0d", seen_done, cyc, last + 4);
    end else n_pass++;
    n_checks++;
    if (bus0.sum_err !== 32'(exp_sum) || bus0.max_err !== 16'(exp_max) ||
        bus0.nz_cnt !== 16'(exp_nz) || bus0.sum_sat !== exp_sat || bus0.busy !== 1'b0) begin
      $display("FAIL run_result sum=%0d max=%0d nz=%0d sat=%b busy=%b required sum=%0d max=%0d nz=%0d sat=%b busy=0",
               bus0.sum_err, bus0.max_err, bus0.nz_cnt, bus0.sum_sat, bus0.busy,
               exp_sum, exp_max, exp_nz, exp_sat);
    end else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus0.done !== 1'b0) $display("FAIL done_pulse done=%b required 0", bus0.done);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus0.start = 0; bus0.n_samples = 0; bus0.in_valid = 0; bus0.a = 0; bus0.b = 0; bus0.r_approx = 0;
    bus1.start = 0; bus1.n_samples = 0; bus1.in_valid = 0; bus1.a = 0; bus1.b = 0; bus1.r_approx = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus0.busy, bus0.in_ready, bus0.done, bus0.sum_sat} !== 4'b0000)
      $display("FAIL reset_ctrl busy/ready/done/sat=%b required 0000",
               {bus0.busy, bus0.in_ready, bus0.done, bus0.sum_sat});
    else n_pass++;
    n_checks++;
    if (bus0.sum_err !== 32'd0 || bus0.max_err !== 16'd0 || bus0.nz_cnt !== 16'd0)
      $display("FAIL reset_stats sum=%0d max=%0d nz=%0d required 0", bus0.sum_err, bus0.max_err, bus0.nz_cnt);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_exact_run();
    clear_q();
    push(3, 5, 15); push(255, 255, 65025); push(0, 7, 0);
    run0(3, 0, 0);
    n_checks++;
    if (bus0.sum_err !== 32'd0 || bus0.max_err !== 16'd0 || bus0.nz_cnt !== 16'd0 || bus0.sum_sat !== 1'b0)
      $display("FAIL exact_run sum=%0d max=%0d nz=%0d sat=%b required 0 0 0 0",
               bus0.sum_err, bus0.max_err, bus0.nz_cnt, bus0.sum_sat);
    else n_pass++;
  endtask

  task automatic test_error_run();
    clear_q();
    push(16, 16, 250); push(10, 10, 100);
    run0(2, 0, 0);
    n_checks++;
    if (bus0.sum_err !== 32'd6 || bus0.max_err !== 16'd6 || bus0.nz_cnt !== 16'd1)
      $display("FAIL error_run sum=%0d max=%0d nz=%0d required 6 6 1", bus0.sum_err, bus0.max_err, bus0.nz_cnt);
    else n_pass++;
    clear_q();
    push(16, 16, 262); push(16, 16, 250);
    run0(2, 0, 0);
    n_checks++;
    if (bus0.sum_err !== 32'd12 || bus0.max_err !== 16'd6 || bus0.nz_cnt !== 16'd2)
      $display("FAIL over_under sum=%0d max=%0d nz=%0d required 12 6 2", bus0.sum_err, bus0.max_err, bus0.nz_cnt);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    clear_q();
    for (int i = 0; i < 4; i++) begin
      int a, b;
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      push(a, b, a * b + 1);
    end
    vpat = '{1, 0, 1, 0, 1, 1};
    run0(4, 2, 0);
    n_checks++;
    if (bus0.nz_cnt !== 16'd4 || bus0.sum_err !== 32'd4)
      $display("FAIL backpressure_count nz=%0d sum=%0d required 4 4", bus0.nz_cnt, bus0.sum_err);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      int n;
      n = $urandom_range(1, 24);
      clear_q();
      push_random(n);
      run0(n, 1, 1);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      int n;
      n = $urandom_range(1, 8);
      clear_q();
      push_random(n);
      run0(n, 0, 0);
    end
  endtask

  task automatic test_saturation();
    int cyc;
    @(negedge clk);
    bus1.start = 1'b1; bus1.n_samples = 16'd2;
    @(negedge clk);
    bus1.start = 1'b0;
    bus1.in_valid = 1'b1; bus1.a = 8'd255; bus1.b = 8'd255; bus1.r_approx = 16'd0;
    @(negedge clk);
    bus1.a = 8'd1; bus1.b = 8'd1; bus1.r_approx = 16'd0;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    cyc = 0;
    while (bus1.done !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (bus1.done !== 1'b1) $display("FAIL sat_done done=%b required 1", bus1.done);
    else n_pass++;
    n_checks++;
    if (bus1.sum_err !== 8'd255 || bus1.sum_sat !== 1'b1 || bus1.max_err !== 16'd65025 || bus1.nz_cnt !== 16'd2)
      $display("FAIL saturation sum=%0d sat=%b max=%0d nz=%0d required 255 1 65025 2",
               bus1.sum_err, bus1.sum_sat, bus1.max_err, bus1.nz_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    bit got_done;
    got_done = 0;
    @(negedge clk);
    bus0.start = 1'b1; bus0.n_samples = 16'd5;
    @(negedge clk);
    bus0.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus0.in_valid = 1'b1; bus0.a = 8'd200; bus0.b = 8'd100; bus0.r_approx = 16'd7;
      @(negedge clk);
    end
    rst = 1'b1; bus0.start = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus0.start = 1'b0; bus0.in_valid = 1'b0;
    n_checks++;
    if ({bus0.busy, bus0.in_ready, bus0.done, bus0.sum_sat} !== 4'b0000 ||
        bus0.sum_err !== 32'd0 || bus0.max_err !== 16'd0 || bus0.nz_cnt !== 16'd0)
      $display("FAIL midrun_reset ctrl=%b sum=%0d max=%0d nz=%0d required all 0",
               {bus0.busy, bus0.in_ready, bus0.done, bus0.sum_sat}, bus0.sum_err, bus0.max_err, bus0.nz_cnt);
    else n_pass++;
    repeat (8) begin
      if (bus0.done === 1'b1 || bus0.busy === 1'b1) got_done = 1;
      @(negedge clk);
    end
    n_checks++;
    if (got_done || bus0.sum_err !== 32'd0 || bus0.nz_cnt !== 16'd0)
      $display("FAIL midrun_quiet done_or_busy=%b sum=%0d nz=%0d required 0 0 0", got_done, bus0.sum_err, bus0.nz_cnt);
    else n_pass++;
    clear_q();
    push(2, 3, 5);
    run0(1, 0, 0);
    n_checks++;
    if (bus0.sum_err !== 32'd1 || bus0.nz_cnt !== 16'd1)
      $display("FAIL after_reset_run sum=%0d nz=%0d required 1 1", bus0.sum_err, bus0.nz_cnt);
    else n_pass++;
  endtask

  task automatic test_zero_length();
    bit saw;
    saw = 0;
    clear_q();
    push_random(5);
    run0(5, 0, 0);
    @(negedge clk);
    bus0.start = 1'b1; bus0.n_samples = 16'd0;
    @(negedge clk);
    bus0.start = 1'b0;
    repeat (8) begin
      if (bus0.busy === 1'b1 || bus0.done === 1'b1 || bus0.in_ready === 1'b1) saw = 1;
      @(negedge clk);
    end
    n_checks++;
    if (saw) $display("FAIL zero_len_activity busy_or_done_seen=%b required 0", saw);
    else n_pass++;
    n_checks++;
    if (bus0.sum_err !== 32'(exp_sum) || bus0.max_err !== 16'(exp_max) || bus0.nz_cnt !== 16'(exp_nz))
      $display("FAIL zero_len_hold sum=%0d max=%0d nz=%0d required %0d %0d %0d",
               bus0.sum_err, bus0.max_err, bus0.nz_cnt, exp_sum, exp_max, exp_nz);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_exact_run();
    test_error_run();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_saturation();
    test_reset_mid_run();
    test_zero_length();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/approx_err_monitor.md
APPROX_ERR_MONITOR -- requirements
Module: approx_err_monitor

Sits directly downstream of the 8x8 approximate multiplier. Consumes its operands and approximate product, and accumulates error statistics against the exact product over a run of N samples.

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of sample count and nonzero-error count.
REQ-002 SHALL have parameter SUM_W, default 32: width of absolute-error accumulator.
REQ-003 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  run request; sampled only in IDLE.
REQ-007 n_samples  input  CNT_W  samples per run; latched on accepted start.
REQ-008 busy  output  1  high in RUN and DRAIN.
REQ-009 in_valid  input  1  sample present on a, b, r_approx.
REQ-010 in_ready  output  1  monitor accepts a sample this cycle.
REQ-011 a, b  input  8 each  unsigned multiplier operands.
REQ-012 r_approx  input  16  approximate product for a, b.
REQ-013 done  output  1  one-cycle pulse at end of run.
REQ-014 sum_err  output  SUM_W  sum of |a*b - r_approx|.
REQ-015 max_err  output  16  maximum |a*b - r_approx|.
REQ-016 nz_cnt  output  CNT_W  count of samples with nonzero error.
REQ-017 sum_sat  output  1  sticky; sum_err saturated this run.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-019 IDLE: start=1 with n_samples!=0 -> latch N, clear sum_err, max_err, nz_cnt, sum_sat and the sample counter, go to RUN next edge.
REQ-020 IDLE: start=1 with n_samples=0 SHALL be ignored; stay IDLE.
REQ-021 start SHALL be ignored in RUN, DRAIN and DONE.
REQ-022 Sample acceptance: in_ready=1 exactly in RUN; a sample is accepted at an edge where in_valid and in_ready are both 1.
REQ-023 RUN -> DRAIN at the edge accepting the N-th sample; in_ready is 0 from the following cycle.
REQ-024 Pipeline stage 1: register exact=a*b (16-bit unsigned), r_approx, and a valid bit.
REQ-025 Pipeline stage 2: register ed=|exact - r_approx| (16-bit unsigned), and a valid bit.
REQ-026 Stage 3 (on each stage-2-valid edge):
  - sum_err += ed, saturating at 2^SUM_W-1; sum_sat set on saturation and held.
  - max_err = max(max_err, ed).
  - nz_cnt += 1 if ed!=0.
REQ-027 Throughput: one sample per cycle, with no bubbles required.
REQ-028 Pipeline latency: a sample accepted at edge k updates the accumulators at edge k+2.
REQ-029 Drain and completion:
  - DRAIN -> DONE when both pipeline valid bits are 0.
  - done=1 during the single DONE cycle, which begins at edge k+3 for last accept at edge k.
  - DONE -> IDLE at the next edge.
REQ-030 Result outputs SHALL hold their values after DONE until the next accepted start clears them.
REQ-031 in_valid while in_ready=0 SHALL have no effect; data is not stored.
REQ-032 Outputs during a run reflect partial accumulation; only values at and after done are defined results.

Reset
REQ-033 rst=1 at an edge SHALL force:
  - state IDLE;
  - pipeline valid bits 0;
  - busy, in_ready, done, sum_sat = 0;
  - sum_err, max_err, nz_cnt = 0;
  - sample counter 0.
REQ-034 Reset during RUN or DRAIN SHALL abort the run with no done pulse; in-flight samples are discarded.
REQ-035 rst SHALL take priority over start and in_valid at the same edge.

Verification
REQ-036 Exact run: N=3; samples (3,5,15), (255,255,65025), (0,7,0), in_valid continuous.
  - Response: done 3 cycles after the 3rd accept; sum_err=0, max_err=0, nz_cnt=0, sum_sat=0.
REQ-037 Error run: N=2; samples (16,16,250), (10,10,100).
  - Response: sum_err=6, max_err=6, nz_cnt=1.
  - Also check: underestimate (250<256) and overestimate cases both yield positive ed.
REQ-038 Backpressure gaps: N=4 with in_valid toggling 1,0,1,0,1,1.
  - Response: exactly 4 samples counted; in_ready=0 after the 4th accept; a start pulsed during the run is ignored.
REQ-039 Saturation: SUM_W=8; N=2; samples (255,255,0), (1,1,0).
  - Response: sum_err=255, sum_sat=1, max_err=65025.
REQ-040 Reset mid-run: N=5; assert rst after 2 accepts.
  - Response: all outputs 0, no done pulse.
  - New start with N=1, sample (2,3,5): done with sum_err=1, nz_cnt=1.
REQ-041 Zero-length: start with n_samples=0 -> busy stays 0 and no done pulse; results from the prior run are unchanged.
